any1_bitfield_pipe: RTL and testbench



---
 rtl/any1_bitfield_pipe.sv | 153 +++++++++++++++
 tb/tb_any1_bitfield_pipe.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/any1_bitfield_pipe.sv
// ANY-1 bitfield execution unit: SET/CLR/CHG/INS/DEP/EXT/EXTU/FFO.
// Two register stages with valid/ready on both sides and a passthrough tag.
module any1_bitfield_pipe #(
    parameter int DWIDTH = 64,
    parameter int TAGW   = 6,
    parameter int LW     = $clog2(DWIDTH)
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              valid_i,
    output logic              ready_o,
    input  logic [2:0]        op_i,
    input  logic [TAGW-1:0]   tag_i,
    input  logic [DWIDTH-1:0] a_i,
    input  logic [DWIDTH-1:0] b_i,
    input  logic [DWIDTH-1:0] c_i,
    input  logic [DWIDTH-1:0] d_i,
    output logic              valid_o,
    input  logic              ready_i,
    output logic [TAGW-1:0]   tag_o,
    output logic [DWIDTH-1:0] o,
    output logic [DWIDTH-1:0] mask_o
);

    localparam logic [2:0] OP_SET  = 3'd0;
    localparam logic [2:0] OP_CLR  = 3'd1;
    localparam logic [2:0] OP_CHG  = 3'd2;
    localparam logic [2:0] OP_INS  = 3'd3;
    localparam logic [2:0] OP_EXT  = 3'd4;
    localparam logic [2:0] OP_EXTU = 3'd5;
    localparam logic [2:0] OP_FFO  = 3'd6;
    localparam logic [2:0] OP_DEP  = 3'd7;

    localparam logic [DWIDTH-1:0] ONES = '1;
    localparam logic [LW-1:0]     TOP  = LW'(DWIDTH - 1);

    logic              s1_valid;
    logic [2:0]        s1_op;
    logic [TAGW-1:0]   s1_tag;
    logic [DWIDTH-1:0] s1_a;
    logic [DWIDTH-1:0] s1_b;
    logic [DWIDTH-1:0] s1_mask;
    logic [LW-1:0]     s1_mb;
    logic [LW-1:0]     s1_mw;

    logic              s2_adv;
    logic              accept;

    assign s2_adv  = !valid_o || ready_i;
    assign ready_o = !s1_valid || s2_adv;
    assign accept  = valid_i && ready_o;

    // Field mask: the ascending run mb..me, or the two ends when me wraps.
    logic [LW-1:0]     mb;
    logic [LW-1:0]     mw;
    logic [LW-1:0]     me;
    logic [DWIDTH-1:0] lo_m;
    logic [DWIDTH-1:0] hi_m;
    logic [DWIDTH-1:0] mask;

    assign mb   = c_i[LW-1:0];
    assign mw   = d_i[LW-1:0];
    assign me   = mb + mw;
    assign lo_m = ONES << mb;
    assign hi_m = ONES >> (TOP - me);
    assign mask = (me >= mb) ? (lo_m & hi_m) : (lo_m | hi_m);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            s1_valid <= 1'b0;
            s1_op    <= '0;
            s1_tag   <= '0;
            s1_a     <= '0;
            s1_b     <= '0;
            s1_mask  <= '0;
            s1_mb    <= '0;
            s1_mw    <= '0;
        end else if (ready_o) begin
            s1_valid <= valid_i;
            if (accept) begin
                s1_op   <= op_i;
                s1_tag  <= tag_i;
                s1_a    <= a_i;
                s1_b    <= b_i;
                s1_mask <= mask;
                s1_mb   <= mb;
                s1_mw   <= mw;
            end
        end
    end

    logic [2*DWIDTH-1:0] rot2;
    logic [2*DWIDTH-1:0] ext2;
    logic [DWIDTH-1:0]   rot;
    logic [DWIDTH-1:0]   f;
    logic [DWIDTH-1:0]   low_m;
    logic [DWIDTH-1:0]   ffo_x;
    logic [LW-1:0]       ffo_idx;
    logic [LW-1:0]       ffo_d;
    logic                ffo_hit;
    logic [DWIDTH-1:0]   res;

    assign rot2  = {s1_b, s1_b} << s1_mb;
    assign rot   = rot2[2*DWIDTH-1:DWIDTH];
    assign ext2  = {s1_b, s1_a} >> s1_mb;
    assign f     = ext2[DWIDTH-1:0];
    assign low_m = ONES >> (TOP - s1_mw);
    assign ffo_x = s1_a & s1_mask;
    assign ffo_d = ffo_idx - s1_mb;

    always_comb begin
        ffo_idx = '0;
        ffo_hit = 1'b0;
        for (int n = 0; n < DWIDTH; n++) begin
            if (ffo_x[n]) begin
                ffo_idx = LW'(n);
                ffo_hit = 1'b1;
            end
        end
    end

    always_comb begin
        res = '0;
        unique case (s1_op)
            OP_SET:  res = s1_a | s1_mask;
            OP_CLR:  res = s1_a & ~s1_mask;
            OP_CHG:  res = s1_a ^ s1_mask;
            OP_INS:  res = (rot & s1_mask) | (s1_a & ~s1_mask);
            OP_DEP:  res = rot & s1_mask;
            OP_EXTU: res = f & low_m;
            OP_EXT:  res = (f & low_m) | (f[s1_mw] ? ~low_m : '0);
            OP_FFO:  res = ffo_hit ? {{(DWIDTH-LW){1'b0}}, ffo_d} : ONES;
            default: res = '0;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            valid_o <= 1'b0;
            o       <= '0;
            mask_o  <= '0;
            tag_o   <= '0;
        end else if (s2_adv) begin
            valid_o <= s1_valid;
            if (s1_valid) begin
                o      <= res;
                mask_o <= s1_mask;
                tag_o  <= s1_tag;
            end
        end
    end

endmodule

// File: tb/tb_any1_bitfield_pipe.sv
// Directed bench for any1_bitfield_pipe at DWIDTH=64: ops, wrap, extract,
// FFO, backpressure ordering and mid-flight reset.
module tb_any1_bitfield_pipe;

    localparam int DW = 64;
    localparam int TW = 6;

    logic          clk = 1'b0;
    logic          rst_i;
    logic          valid_i;
    logic          ready_o;
    logic [2:0]    op_i;
    logic [TW-1:0] tag_i;
    logic [DW-1:0] a_i, b_i, c_i, d_i;
    logic          valid_o;
    logic          ready_i;
    logic [TW-1:0] tag_o;
    logic [DW-1:0] o;
    logic [DW-1:0] mask_o;

    int total  = 0;
    int passed = 0;

    logic [DW-1:0] r_o;
    logic [DW-1:0] r_mask;
    logic          r_valid;

    any1_bitfield_pipe #(.DWIDTH(DW), .TAGW(TW)) dut (
        .clk_i   (clk),
        .rst_i   (rst_i),
        .valid_i (valid_i),
        .ready_o (ready_o),
        .op_i    (op_i),
        .tag_i   (tag_i),
        .a_i     (a_i),
        .b_i     (b_i),
        .c_i     (c_i),
        .d_i     (d_i),
        .valid_o (valid_o),
        .ready_i (ready_i),
        .tag_o   (tag_o),
        .o       (o),
        .mask_o  (mask_o)
    );

    always #5 clk = ~clk;

    task automatic drive(input logic [2:0] op, input logic [TW-1:0] tg,
                         input logic [DW-1:0] a, input logic [DW-1:0] b,
                         input int mb, input int mw);
        valid_i = 1'b1;
        op_i    = op;
        tag_i   = tg;
        a_i     = a;
        b_i     = b;
        c_i     = DW'(mb);
        d_i     = DW'(mw);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Issue one op into an empty pipe and sample exactly two edges later.
    task automatic run_op(input logic [2:0] op, input logic [DW-1:0] a,
                          input logic [DW-1:0] b, input int mb, input int mw);
        drive(op, 6'd9, a, b, mb, mw);
        tick();
        valid_i = 1'b0;
        tick();
        r_valid = valid_o;
        r_o     = o;
        r_mask  = mask_o;
        tick();
    endtask

    task automatic test_reset();
        rst_i   = 1'b1;
        valid_i = 1'b0;
        ready_i = 1'b1;
        op_i = '0; tag_i = '0; a_i = '0; b_i = '0; c_i = '0; d_i = '0;
        tick();
        tick();
        rst_i = 1'b0;
        total++;
        if (valid_o !== 1'b0) $display("FAIL reset valid_o got %b want 0", valid_o);
        else passed++;
        total++;
        if (ready_o !== 1'b1) $display("FAIL reset ready_o got %b want 1", ready_o);
        else passed++;
        total++;
        if (o !== '0) $display("FAIL reset o got %h want 0", o);
        else passed++;
        total++;
        if (mask_o !== '0) $display("FAIL reset mask_o got %h want 0", mask_o);
        else passed++;
        total++;
        if (tag_o !== '0) $display("FAIL reset tag_o got %h want 0", tag_o);
        else passed++;
    endtask

    task automatic test_set_ins();
        run_op(3'd0, 64'h0, 64'h0, 4, 3);
        total++;
        if (r_valid !== 1'b1) $display("FAIL set latency valid got %b want 1", r_valid);
        else passed++;
        total++;
        if (r_o !== 64'h00000000000000F0) $display("FAIL set o got %h want %h", r_o, 64'hF0);
        else passed++;
        total++;
        if (r_mask !== 64'hF0) $display("FAIL set mask got %h want %h", r_mask, 64'hF0);
        else passed++;
        run_op(3'd3, 64'hFFFFFFFFFFFFFFFF, 64'h5, 8, 3);
        total++;
        if (r_o !== 64'hFFFFFFFFFFFFF5FF)
            $display("FAIL ins o got %h want %h", r_o, 64'hFFFFFFFFFFFFF5FF);
        else passed++;
    endtask

    task automatic test_wrap();
        run_op(3'd1, 64'hFFFFFFFFFFFFFFFF, 64'h0, 62, 3);
        total++;
        if (r_mask !== 64'hC000000000000003)
            $display("FAIL wrap mask got %h want %h", r_mask, 64'hC000000000000003);
        else passed++;
        total++;
        if (r_o !== 64'h3FFFFFFFFFFFFFFC)
            $display("FAIL wrap clr got %h want %h", r_o, 64'h3FFFFFFFFFFFFFFC);
        else passed++;
        run_op(3'd7, 64'h1234, 64'hF, 62, 3);
        total++;
        if (r_o !== 64'hC000000000000003)
            $display("FAIL wrap dep got %h want %h", r_o, 64'hC000000000000003);
        else passed++;
        run_op(3'd2, 64'h0, 64'h0, 5, 63);
        total++;
        if (r_o !== 64'hFFFFFFFFFFFFFFFF)
            $display("FAIL full chg got %h want all ones", r_o);
        else passed++;
    endtask

    task automatic test_extract();
        run_op(3'd5, 64'hA00, 64'h0, 8, 3);
        total++;
        if (r_o !== 64'hA) $display("FAIL extu got %h want %h", r_o, 64'hA);
        else passed++;
        run_op(3'd4, 64'hA00, 64'h0, 8, 3);
        total++;
        if (r_o !== 64'hFFFFFFFFFFFFFFFA)
            $display("FAIL ext got %h want %h", r_o, 64'hFFFFFFFFFFFFFFFA);
        else passed++;
        run_op(3'd5, 64'h0, 64'h1, 63, 1);
        total++;
        if (r_o !== 64'h2) $display("FAIL extu cross got %h want %h", r_o, 64'h2);
        else passed++;
    endtask

    task automatic test_ffo();
        run_op(3'd6, 64'h10000, 64'h0, 8, 15);
        total++;
        if (r_o !== 64'd8) $display("FAIL ffo hit got %h want 8", r_o);
        else passed++;
        run_op(3'd6, 64'h10000, 64'h0, 0, 7);
        total++;
        if (r_o !== 64'hFFFFFFFFFFFFFFFF) $display("FAIL ffo none got %h want all ones", r_o);
        else passed++;
        run_op(3'd6, 64'h1, 64'h0, 60, 7);
        total++;
        if (r_o !== 64'd4) $display("FAIL ffo wrap got %h want 4", r_o);
        else passed++;
    endtask

    task automatic test_back_to_back();
        ready_i = 1'b0;
        drive(3'd0, 6'd1, 64'h0, 64'h0, 1, 0);
        tick();
        drive(3'd0, 6'd2, 64'h0, 64'h0, 2, 0);
        tick();
        drive(3'd0, 6'd3, 64'h0, 64'h0, 3, 0);
        total++;
        if (ready_o !== 1'b0) $display("FAIL bp ready_o got %b want 0", ready_o);
        else passed++;
        for (int i = 0; i < 3; i++) begin
            tick();
            total++;
            if (valid_o !== 1'b1 || tag_o !== 6'd1 || o !== 64'h2)
                $display("FAIL bp stall v=%b tag=%0d o=%h want 1/1/2", valid_o, tag_o, o);
            else passed++;
        end
        ready_i = 1'b1;
        #1;
        total++;
        if (ready_o !== 1'b1) $display("FAIL bp release ready_o got %b want 1", ready_o);
        else passed++;
        tick();
        valid_i = 1'b0;
        total++;
        if (valid_o !== 1'b1 || tag_o !== 6'd2 || o !== 64'h4)
            $display("FAIL bp second v=%b tag=%0d o=%h want 1/2/4", valid_o, tag_o, o);
        else passed++;
        tick();
        total++;
        if (valid_o !== 1'b1 || tag_o !== 6'd3 || o !== 64'h8)
            $display("FAIL bp third v=%b tag=%0d o=%h want 1/3/8", valid_o, tag_o, o);
        else passed++;
        tick();
        total++;
        if (valid_o !== 1'b0) $display("FAIL bp drain valid_o got %b want 0", valid_o);
        else passed++;
    endtask

    task automatic test_mid_reset();
        ready_i = 1'b0;
        drive(3'd0, 6'd4, 64'h0, 64'h0, 0, 7);
        tick();
        drive(3'd0, 6'd5, 64'h0, 64'h0, 8, 7);
        tick();
        valid_i = 1'b0;
        total++;
        if (valid_o !== 1'b1 || ready_o !== 1'b0)
            $display("FAIL full pipe v=%b r=%b want 1/0", valid_o, ready_o);
        else passed++;
        rst_i = 1'b1;
        tick();
        rst_i   = 1'b0;
        ready_i = 1'b1;
        total++;
        if (valid_o !== 1'b0 || ready_o !== 1'b1)
            $display("FAIL mid reset v=%b r=%b want 0/1", valid_o, ready_o);
        else passed++;
        for (int i = 0; i < 4; i++) begin
            tick();
            total++;
            if (valid_o !== 1'b0) $display("FAIL stale result cycle %0d valid_o=%b", i, valid_o);
            else passed++;
        end
    endtask

    initial begin
        test_reset();
        test_set_ins();
        test_wrap();
        test_extract();
        test_ffo();
        test_back_to_back();
        test_mid_reset();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
